// File: rtl/hazard_stall_ctrl.sv
// Purpose: hazard/stall control for the 5-stage MIPS core (Tuse/Tnew data hazards + mult/div busy sequencing).
// Latency: stall outputs are combinational, same cycle; md_busy is registered, high MULT_CYC/DIV_CYC cycles after issue.
// Backpressure: a stall holds PC and F/D and bubbles D/E; optional STALL_CNT_EN macro adds a saturating stall_cnt output.
module hazard_stall_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rsD,
   input  logic [4:0]  rtD,
   input  logic [1:0]  Tuse_rs,
   input  logic [1:0]  Tuse_rt,
   input  logic [4:0]  A3E,
   input  logic [4:0]  A3M,
   input  logic [1:0]  TnewE,
   input  logic [1:0]  TnewM,
   input  logic        md_startE,
   input  logic        md_typeE,
   input  logic        md_useD,
   output logic        PC_EN,
   output logic        FD_EN,
   output logic        DE_CLR,
`ifdef STALL_CNT_EN
   output logic [31:0] stall_cnt,
`endif
   output logic        md_busy
);

   logic [3:0] md_cnt;
   logic [3:0] md_cnt_nxt;
   logic       md_busy_q;
   logic       stall_rs;
   logic       stall_rt;
   logic       md_stall;
   logic       stall;

   // Register-read hazards the forwarding network cannot cover; $0 is never a real dependency.
   always_comb begin
      stall_rs = 1'b0;
      stall_rt = 1'b0;
      if (rsD != 5'd0) begin
         stall_rs = ((rsD == A3E) && (TnewE > Tuse_rs)) ||
                    ((rsD == A3M) && (TnewM > Tuse_rs));
      end
      if (rtD != 5'd0) begin
         stall_rt = ((rtD == A3E) && (TnewE > Tuse_rt)) ||
                    ((rtD == A3M) && (TnewM > Tuse_rt));
      end
   end

   // Busy countdown next value: load only from idle, so a start pulse while busy is dropped.
   always_comb begin
      md_cnt_nxt = md_cnt;
      if (md_startE && (md_cnt == 4'd0)) begin
         md_cnt_nxt = md_typeE ? 4'(DIV_CYC) : 4'(MULT_CYC);
      end else if (md_cnt != 4'd0) begin
         md_cnt_nxt = md_cnt - 4'd1;
      end
   end

   // Countdown and its busy flag; the flag is registered alongside so md_busy has no comb path.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         md_cnt    <= 4'd0;
         md_busy_q <= 1'b0;
      end else begin
         md_cnt    <= md_cnt_nxt;
         md_busy_q <= (md_cnt_nxt != 4'd0);
      end
   end

   assign md_busy = md_busy_q;

   // Only mult/div-class instructions wait on the unit; the issue cycle itself also counts as busy.
   always_comb begin
      md_stall = md_useD && (md_startE || md_busy_q);
      stall    = stall_rs || stall_rt || md_stall;
      PC_EN    = ~stall;
      FD_EN    = ~stall;
      DE_CLR   = stall;
   end

`ifdef STALL_CNT_EN
   // Count stalled cycles, saturating rather than wrapping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= 32'd0;
      end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Purpose: scoreboard bench for hazard_stall_ctrl; stimulus pushes expected outputs, a negedge monitor pops and compares.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge of the same cycle.
// Backpressure: none; one expectation per driven cycle, drained before the summary.
module tb_hazard_stall_ctrl;

   logic        clk;
   logic        reset;
   logic [4:0]  rsD, rtD, A3E, A3M;
   logic [1:0]  Tuse_rs, Tuse_rt, TnewE, TnewM;
   logic        md_startE, md_typeE, md_useD;
   logic        PC_EN, FD_EN, DE_CLR, md_busy;
`ifdef STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   hazard_stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .rsD       (rsD),
      .rtD       (rtD),
      .Tuse_rs   (Tuse_rs),
      .Tuse_rt   (Tuse_rt),
      .A3E       (A3E),
      .A3M       (A3M),
      .TnewE     (TnewE),
      .TnewM     (TnewM),
      .md_startE (md_startE),
      .md_typeE  (md_typeE),
      .md_useD   (md_useD),
      .PC_EN     (PC_EN),
      .FD_EN     (FD_EN),
      .DE_CLR    (DE_CLR),
`ifdef STALL_CNT_EN
      .stall_cnt (stall_cnt),
`endif
      .md_busy   (md_busy)
   );

   typedef struct {
      logic [3:0]  outs;   // {PC_EN, FD_EN, DE_CLR, md_busy}
      logic [31:0] cnt;
      string       nm;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] stalls_so_far = 32'd0;
   logic        drain_chk = 1'b0;
   logic        drain_done = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One directed cycle: drive inputs after the edge and queue the hand-computed response.
   task automatic step(input logic rst,
                       input logic [4:0] rs, input logic [1:0] tur,
                       input logic [4:0] rt, input logic [1:0] tut,
                       input logic [4:0] a3e, input logic [1:0] te,
                       input logic [4:0] a3m, input logic [1:0] tm,
                       input logic st, input logic ty, input logic ud,
                       input logic e_stall, input logic e_busy, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst; rsD = rs; Tuse_rs = tur; rtD = rt; Tuse_rt = tut;
      A3E = a3e; TnewE = te; A3M = a3m; TnewM = tm;
      md_startE = st; md_typeE = ty; md_useD = ud;
      e.outs = {~e_stall, ~e_stall, e_stall, e_busy};
      e.cnt  = rst ? stalls_so_far : 32'd0;
      e.nm   = nm;
      sb_q.push_back(e);
      if (!rst) stalls_so_far = 32'd0;
      else if (e_stall) stalls_so_far = stalls_so_far + 32'd1;
   endtask

   // Monitor: compare every queued expectation against the DUT on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_cmp++;
         if ({PC_EN, FD_EN, DE_CLR, md_busy} !== e.outs) begin
            n_bad++;
            $display("FAIL %s: pc/fd/clr/busy got %b expected %b at %0t",
                     e.nm, {PC_EN, FD_EN, DE_CLR, md_busy}, e.outs, $time);
         end
`ifdef STALL_CNT_EN
         n_cmp++;
         if (stall_cnt !== e.cnt) begin
            n_bad++;
            $display("FAIL %s_cnt: stall_cnt got %0d expected %0d", e.nm, stall_cnt, e.cnt);
         end
`endif
      end else if (drain_chk && !drain_done) begin
         n_cmp++;
         drain_done = 1'b1;
      end
   end

   initial begin
      reset = 1'b0; rsD = 5'd0; rtD = 5'd0; Tuse_rs = 2'd3; Tuse_rt = 2'd3;
      A3E = 5'd0; A3M = 5'd0; TnewE = 2'd0; TnewM = 2'd0;
      md_startE = 1'b0; md_typeE = 1'b0; md_useD = 1'b0;

      // Reset: idle inputs give no stall, comb equations still active
      step(0, 0,3, 0,3, 0,0, 0,0, 0,0,0, 0,0, "rst_idle");
      step(0, 5,1, 0,3, 5,2, 0,0, 0,0,0, 1,0, "rst_loaduse");
      // Data hazards
      step(1, 5,1, 0,3, 5,2, 0,0, 0,0,0, 1,0, "loaduse_E");
      step(1, 5,1, 0,3, 0,0, 5,1, 0,0,0, 0,0, "loaduse_M_fwd");
      step(1, 0,0, 0,3, 0,2, 0,0, 0,0,0, 0,0, "r0_no_stall");
      step(1, 8,0, 0,3, 8,2, 0,0, 0,0,0, 1,0, "r8_stall");
      step(1, 0,3, 9,1, 0,0, 9,2, 0,0,0, 1,0, "rt_M_stall");
      step(1, 0,3, 9,1, 0,0, 9,1, 0,0,0, 0,0, "rt_M_equal");
      step(1, 5,3, 0,3, 5,2, 0,0, 0,0,0, 0,0, "rs_unused");
      // mult then mflo held in D: 6 stall cycles
      step(1, 0,3, 0,3, 0,0, 0,0, 1,0,1, 1,0, "mult_issue");
      for (int i = 0; i < 5; i++)
         step(1, 0,3, 0,3, 0,0, 0,0, 0,0,1, 1,1, "mult_busy");
      step(1, 0,3, 0,3, 0,0, 0,0, 0,0,1, 0,0, "mult_done");
      // div then unrelated instructions; a second start while busy is ignored
      step(1, 0,3, 0,3, 0,0, 0,0, 1,1,0, 0,0, "div_issue");
      for (int i = 1; i <= 10; i++)
         step(1, 0,3, 0,3, 0,0, 0,0, (i == 3),0,0, 0,1, "div_busy");
      step(1, 0,3, 0,3, 0,0, 0,0, 0,0,0, 0,0, "div_done");
      // Data hazard coinciding with md issue: one stall only
      step(1, 5,1, 0,3, 5,2, 0,0, 1,0,1, 1,0, "both_stall");
      for (int i = 0; i < 5; i++)
         step(1, 0,3, 0,3, 0,0, 0,0, 0,0,0, 0,1, "mult_drain");
      step(1, 0,3, 0,3, 0,0, 0,0, 0,0,0, 0,0, "drain_idle");
      // Async reset at the 4th busy cycle of a div
      step(1, 0,3, 0,3, 0,0, 0,0, 1,1,0, 0,0, "div2_issue");
      for (int i = 0; i < 3; i++)
         step(1, 0,3, 0,3, 0,0, 0,0, 0,0,0, 0,1, "div2_busy");
      step(0, 0,3, 0,3, 0,0, 0,0, 0,0,0, 0,0, "rst_mid_div");
      step(1, 0,3, 0,3, 0,0, 0,0, 0,0,1, 0,0, "post_rst_useD");
      step(1, 5,1, 0,3, 5,2, 0,0, 0,0,0, 1,0, "post_rst_loaduse");
      step(1, 0,3, 0,3, 0,0, 0,0, 0,0,0, 0,0, "post_rst_idle");

      @(posedge clk);
      #1;
      drain_chk = 1'b1;
      repeat (3) @(posedge clk);
      if (!drain_done) begin
         $display("FAIL drain: monitor never emptied scoreboard, %0d left", sb_q.size());
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      end else begin
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      end
      $finish;
   end

endmodule
